// File: rtl/mem_arbiter.sv
// Arbiter that shares one single-port RAM between an instruction-fetch port and a data port.
// Define MEM_ARBITER_ROUND_ROBIN_EN to alternate on collisions; by default the data port wins.
module mem_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_wren,
  output logic        ram_rden,
  input  logic [31:0] ram_q,
  output logic        stall
);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GNT_IF = 3'd1,
    GNT_D  = 3'd2,
    RSP_IF = 3'd3,
    RSP_D  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        cmd_we_q, cmd_we_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_wdata_q, cmd_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        pick_d_s;

  // Collision resolution: the other port under round-robin, otherwise the data port
  always_comb begin
    if (if_req && d_req) begin
      pick_d_s = RR_EN ? ~last_grant_q : 1'b1;
    end else begin
      pick_d_s = d_req;
    end
  end

  // Next state, command capture at each decision, and read-data capture
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cmd_we_d     = cmd_we_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      GNT_IF: state_d = RSP_IF;
      GNT_D:  state_d = RSP_D;
      default: begin
        // IDLE and both RSP states decide; illegal encodings recover here too
        if (if_req || d_req) begin
          state_d      = pick_d_s ? GNT_D : GNT_IF;
          last_grant_d = pick_d_s;
          cmd_we_d     = pick_d_s & d_we;
          cmd_addr_d   = pick_d_s ? d_addr : if_addr;
          cmd_wdata_d  = pick_d_s ? d_wdata : cmd_wdata_q;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    if (state_q == RSP_IF) begin
      if_rdata_d = ram_q;
    end else begin
      if_rdata_d = if_rdata_q;
    end
    if ((state_q == RSP_D) && !cmd_we_q) begin
      d_rdata_d = ram_q;
    end else begin
      d_rdata_d = d_rdata_q;
    end
  end

  // State, command and returned-data registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= 32'h0000_0000;
      cmd_wdata_q  <= 32'h0000_0000;
      if_rdata_q   <= 32'h0000_0000;
      d_rdata_q    <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cmd_we_q     <= cmd_we_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // RAM strobes are decoded from the state register so reset drops them immediately
  assign ram_addr  = cmd_addr_q;
  assign ram_wdata = cmd_wdata_q;
  assign ram_wren  = (state_q == GNT_D) && cmd_we_q;
  assign ram_rden  = (state_q == GNT_IF) || ((state_q == GNT_D) && !cmd_we_q);

  assign if_valid  = (state_q == RSP_IF);
  assign d_valid   = (state_q == RSP_D);

  // ram_q arrives in the response cycle, so it is forwarded there and held afterwards
  assign if_rdata  = (state_q == RSP_IF) ? ram_q : if_rdata_q;
  assign d_rdata   = ((state_q == RSP_D) && !cmd_we_q) ? ram_q : d_rdata_q;

  assign stall     = (if_req && !if_valid) || (d_req && !d_valid);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports clock (input, 1, single clock) and reset (input, 1, asynchronous, active-high); both are already decided.
REQ-002 SHALL have if_req, input, 1: fetch port read request.
REQ-003 SHALL have if_addr, input, 32: fetch word address.
REQ-004 SHALL have if_rdata, output, 32: last fetched word.
REQ-005 SHALL have if_valid, output, 1: one-cycle fetch completion pulse.
REQ-006 SHALL have d_req, input, 1: data port request.
REQ-007 SHALL have d_we, input, 1: data port write (1) or read (0).
REQ-008 SHALL have d_addr and d_wdata, inputs, 32 each: data port address and write data.
REQ-009 SHALL have d_rdata, output, 32: last data word read.
REQ-010 SHALL have d_valid, output, 1: one-cycle data completion pulse, for reads and writes.
REQ-011 SHALL have ram_addr and ram_wdata, outputs, 32 each, plus ram_wren and ram_rden, outputs, 1 each: shared single-port RAM command.
REQ-012 SHALL have ram_q, input, 32: RAM read data, valid one cycle after the command cycle.
REQ-013 SHALL have stall, output, 1: pipeline hold request.

Function
REQ-014 SHALL implement FSM states IDLE, GNT_IF, GNT_D, RSP_IF and RSP_D.
REQ-015 In IDLE, or in any RSP state, a decision SHALL be made when any request is pending; the winner's command is registered and the FSM enters GNT_IF or GNT_D, otherwise it enters IDLE.
REQ-016 In a GNT state, ram_* SHALL drive the registered command for exactly one cycle, then the FSM SHALL enter the matching RSP state.
REQ-017 Outside GNT states, ram_wren and ram_rden SHALL be 0, and ram_addr and ram_wdata SHALL hold their last values.
REQ-018 In RSP_IF, if_valid SHALL be 1 and if_rdata SHALL load ram_q; if_rdata SHALL hold until the next RSP_IF.
REQ-019 In RSP_D, d_valid SHALL be 1; for reads, d_rdata SHALL load ram_q; for writes, d_rdata SHALL be unchanged.
REQ-020 Latency SHALL be: request first seen in cycle N with the port idle, so valid is asserted in cycle N+2. Back-to-back grants SHALL add no idle cycle.
REQ-021 Requesters SHALL hold req, addr, we and wdata stable until valid; the arbiter SHALL sample them only at the decision.
REQ-022 A req still high in the cycle of its own valid SHALL count as a new request.
REQ-023 stall SHALL equal (if_req & ~if_valid) | (d_req & ~d_valid), combinationally.
REQ-024 A write command SHALL set ram_wren=1 and ram_rden=0; a read SHALL set ram_wren=0 and ram_rden=1; the two SHALL never be 1 together.
REQ-025 Addresses SHALL pass through unmodified as full 32-bit word addresses; the arbiter SHALL perform no arithmetic on them.
REQ-026 A last_grant register SHALL record the port of each grant (0=IF, 1=D).

Reset
REQ-027 Reset SHALL asynchronously force state IDLE, last_grant=0, all ram_* outputs=0, if_rdata and d_rdata=0, and if_valid and d_valid=0.
REQ-028 Reset asserted mid-operation SHALL abort the access with no completion pulse; ram_wren SHALL drop in the same cycle as reset.
REQ-029 After reset deasserts, pending requests SHALL be re-arbitrated from IDLE.

Configuration
REQ-030 With macro MEM_ARBITER_ROUND_ROBIN_EN defined, simultaneous requests SHALL go to the port not equal to last_grant.
REQ-031 Without MEM_ARBITER_ROUND_ROBIN_EN, simultaneous requests SHALL always go to the data port (fixed priority); last_grant SHALL still be kept.

Verification
REQ-032 Fetch only: if_req=1, if_addr=0x00400000, ram_q=0x00000013 -> GNT_IF with ram_rden=1 at N+1; if_valid=1 and if_rdata=0x00000013 at N+2; stall=1 in N and N+1.
REQ-033 Data write: d_req=1, d_we=1, d_addr=0x10010000, d_wdata=0xDEADBEEF -> at N+1, ram_wren=1 with that address and data; d_valid=1 at N+2; d_rdata unchanged.
REQ-034 Simultaneous if_req and d_req, last_grant=0, macro defined -> D served first, then IF granted with no idle cycle; valids at N+2 and N+4.
REQ-035 Same as REQ-034 with macro undefined and last_grant=1 -> D still served first.
REQ-036 Reset during a GNT_D write -> ram_wren=0 in the same cycle, no d_valid; after release with d_req held, the write reissues and d_valid arrives 2 cycles later.
REQ-037 Continuous if_req for 6 cycles with no d_req -> if_valid pulses every 2 cycles with consecutive addresses 0x00400000, 0x00400001, 0x00400002 returned in order.
